// File: rtl/fir_serial_mac.sv
// Runtime-programmable FIR filter with a single time-shared multiply-accumulate unit.
// Samples and results use valid/ready handshakes; the result is rounded and saturated.
module fir_serial_mac #(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned IW    = 12,
  parameter int unsigned TW    = 12,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_tap_wr,
  input  logic [$clog2(NTAPS)-1:0]   i_tap_addr,
  input  logic signed [TW-1:0]       i_tap_data,
  output logic                       o_tap_err,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic signed [IW-1:0]       i_sample,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [OW-1:0]       o_result
);

  localparam int unsigned AddrW = $clog2(NTAPS);
  localparam int unsigned PW    = IW + TW;
  localparam int unsigned AW    = PW + AddrW;
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NTAPS - 1);
  localparam logic signed [AW:0] RoundC =
    (SHIFT == 0) ? '0 : ((AW + 1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_t;

  state_t                  r_state, w_state_next;
  logic signed [TW-1:0]    r_taps [NTAPS];
  logic signed [IW-1:0]    r_x    [NTAPS];
  logic [AddrW-1:0]        r_wptr, r_idx, w_wptr_inc, w_rd;
  logic signed [AW-1:0]    r_acc, w_acc_sum;
  logic signed [PW-1:0]    w_prod;
  logic signed [AW:0]      w_rnd, w_shr;
  logic [AW-OW+1:0]        w_hi;
  logic signed [OW-1:0]    r_result, w_sat;
  logic                    r_valid, r_tap_err;
  logic                    w_accept, w_last, w_tap_ok;

  assign o_ready   = (r_state == StIdle);
  assign o_valid   = r_valid;
  assign o_result  = r_result;
  assign o_tap_err = r_tap_err;

  assign w_tap_ok   = (32'(i_tap_addr) < NTAPS);
  assign w_wptr_inc = (r_wptr == LastIdx) ? '0 : r_wptr + 1'b1;
  // Circular read index: newest sample sits at r_wptr, tap k reads k steps back.
  assign w_rd = (r_wptr >= r_idx) ? r_wptr - r_idx
                                  : AddrW'(NTAPS - 32'(r_idx) + 32'(r_wptr));

  assign w_prod    = r_taps[r_idx] * r_x[w_rd];
  assign w_acc_sum = r_acc + AW'(w_prod);
  assign w_rnd     = (AW + 1)'(w_acc_sum) + RoundC;
  assign w_shr     = w_rnd >>> SHIFT;
  assign w_hi      = w_shr[AW:OW-1];

  always_comb begin
    w_sat = w_shr[OW-1:0];
    if (!((&w_hi) || !(|w_hi))) begin
      w_sat = w_shr[AW] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_valid) begin
          w_accept     = 1'b1;
          w_state_next = StMac;
        end
      end
      StMac: begin
        if (r_idx == LastIdx) begin
          w_last       = 1'b1;
          w_state_next = StOut;
        end
      end
      StOut: begin
        if (i_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_taps[i] <= '0;
        r_x[i]    <= '0;
      end
      r_wptr    <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_tap_err <= 1'b0;
    end else begin
      // Writes outside IDLE are dropped so an in-flight result keeps its taps.
      r_tap_err <= i_tap_wr && ((r_state != StIdle) || !w_tap_ok);
      if (i_tap_wr && (r_state == StIdle) && w_tap_ok) r_taps[i_tap_addr] <= i_tap_data;
      if (w_accept) begin
        r_wptr          <= w_wptr_inc;
        r_x[w_wptr_inc] <= i_sample;
        r_acc           <= '0;
        r_idx           <= '0;
      end
      if (r_state == StMac) begin
        r_acc <= w_acc_sum;
        r_idx <= r_idx + 1'b1;
      end
      if (w_last) begin
        r_result <= w_sat;
        r_valid  <= 1'b1;
      end
      if ((r_state == StOut) && i_ready) r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench: two instances (SHIFT=0 and SHIFT=4, NTAPS=4) share all inputs;
// expected values are hand-computed constants.
module tb_fir_serial_mac;

  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              tap_wr;
  logic [1:0]        tap_addr;
  logic signed [11:0] tap_data;
  logic              valid_in, ready_in;
  logic signed [11:0] sample;
  logic              err_a, rdy_a, vld_a, err_b, rdy_b, vld_b;
  logic signed [15:0] res_a, res_b;

  int n_vec = 0;
  int n_err = 0;

  fir_serial_mac #(.NTAPS(NT), .IW(12), .TW(12), .OW(16), .SHIFT(0)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_tap_wr(tap_wr), .i_tap_addr(tap_addr),
    .i_tap_data(tap_data), .o_tap_err(err_a), .i_valid(valid_in), .o_ready(rdy_a),
    .i_sample(sample), .o_valid(vld_a), .i_ready(ready_in), .o_result(res_a)
  );

  fir_serial_mac #(.NTAPS(NT), .IW(12), .TW(12), .OW(16), .SHIFT(4)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_tap_wr(tap_wr), .i_tap_addr(tap_addr),
    .i_tap_data(tap_data), .o_tap_err(err_b), .i_valid(valid_in), .o_ready(rdy_b),
    .i_sample(sample), .o_valid(vld_b), .i_ready(ready_in), .o_result(res_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input int addr, input int data);
    tap_wr   = 1'b1;
    tap_addr = 2'(addr);
    tap_data = 12'(data);
    step();
    tap_wr = 1'b0;
    check("tap_err_idle", int'(err_a), 0);
  endtask

  // Present a sample and return once it has been accepted (just after the accept edge).
  task automatic push(input int s);
    int guard;
    guard    = 0;
    valid_in = 1'b1;
    sample   = 12'(s);
    while (!rdy_a && guard < 50) begin
      step();
      guard++;
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int already);
    int lat;
    lat = already;
    while (!vld_a && lat < 50) begin
      step();
      lat++;
    end
    check(tag, lat, NT);
  endtask

  task automatic run(input string tag, input int s, input int exp_a, input int exp_b);
    push(s);
    wait_valid({tag, "_lat"}, 0);
    check({tag, "_a"}, int'(res_a), exp_a);
    check({tag, "_b"}, int'(res_b), exp_b);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    tap_wr   = 1'b0;
    tap_addr = '0;
    tap_data = '0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    sample   = '0;
    step();
    step();
    check("rst_valid", int'(vld_a), 0);
    check("rst_ready", int'(rdy_a), 1);
    check("rst_result", int'(res_a), 0);
    check("rst_tap_err", int'(err_a), 0);
    rst_n = 1'b1;
    step();

    // Impulse response through taps {1,2,3,4}.
    write_tap(0, 1); write_tap(1, 2); write_tap(2, 3); write_tap(3, 4);
    run("imp0", 1, 1, 0);
    run("imp1", 0, 2, 0);
    run("imp2", 0, 3, 0);
    run("imp3", 0, 4, 0);
    run("imp4", 0, 0, 0);

    // Saturation at both rails.
    write_tap(0, 2047); write_tap(1, 2047); write_tap(2, 2047); write_tap(3, 2047);
    run("satp0", 2047, 32767, 32767);
    run("satp1", 2047, 32767, 32767);
    run("satp2", 2047, 32767, 32767);
    run("satp3", 2047, 32767, 32767);
    run("satn0", -2048, 32767, 32767);
    run("satn1", -2048, -4094, -256);
    run("satn2", -2048, -32768, -32768);
    run("satn3", -2048, -32768, -32768);

    // Rounding (instance b, SHIFT=4).
    write_tap(0, 1); write_tap(1, 0); write_tap(2, 0); write_tap(3, 0);
    run("rnd8", 8, 8, 1);
    run("rnd7", 7, 7, 0);
    run("rndm8", -8, -8, 0);
    run("rndm9", -9, -9, -1);

    // Back-pressure: result held while downstream stalls, new samples ignored.
    ready_in = 1'b0;
    push(77);
    wait_valid("bp_lat", 0);
    valid_in = 1'b1;
    sample   = 12'(99);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", int'(vld_a), 1);
      check("bp_result_a", int'(res_a), 77);
      check("bp_result_b", int'(res_b), 5);
      check("bp_ready", int'(rdy_a), 0);
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    check("bp_release_valid", int'(vld_a), 0);
    check("bp_release_ready", int'(rdy_a), 1);
    step();
    check("bp_single_xfer", int'(vld_a), 0);

    // Tap write during MAC is rejected and flagged.
    push(5);
    tap_wr   = 1'b1;
    tap_addr = 2'd0;
    tap_data = 12'sd3;
    step();
    tap_wr = 1'b0;
    check("mac_wr_err", int'(err_a), 1);
    step();
    check("mac_wr_err_clr", int'(err_a), 0);
    wait_valid("mac_wr_lat", 2);
    check("mac_wr_old_a", int'(res_a), 5);
    check("mac_wr_old_b", int'(res_b), 0);
    step();
    write_tap(0, 3);
    run("idle_wr", 5, 15, 1);

    // Asynchronous reset in the middle of a computation.
    push(9);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(vld_a), 0);
    check("mid_rst_ready", int'(rdy_a), 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NT + 2; i++) begin
      step();
      check("post_rst_no_out", int'(vld_a), 0);
    end
    run("post_rst", 100, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
